// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//   Upstream command stage for the 16-bit ALU breadboard. {opcode,a,b} commands
//   are buffered in a small FIFO and issued to the ALU one at a time. Each op is
//   followed by one CLEAR cycle. The ALU result and overflow are captured after
//   the ALU register latency and offered on a valid/ready result port.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (cmd_ready = !full && !rst)
//   cmd_opcode/cmd_a/cmd_b   command payload
//   alu_opcode/alu_a/alu_b   registered drive to the ALU control and input muxes
//   alu_result/alu_overflow  ALU final output and adder overflow
//   res_valid/res_ready      result handshake
//   res_data/res_overflow    captured result and overflow (ADD/SUB only)
//   res_illegal              captured command used an unsupported opcode
//   busy                     sequencer active or commands still queued
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
   parameter int              WIDTH    = 16,
   parameter int              OP_W     = 4,
   parameter int              DEPTH    = 4,
   parameter int              ALU_LAT  = 1,
   parameter logic [OP_W-1:0] CLEAR_OP = 4'b1111
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [OP_W-1:0]  cmd_opcode,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   output logic [OP_W-1:0]  alu_opcode,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_overflow,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_overflow,
   output logic             res_illegal,
   output logic             busy
);

   localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W     = PTR_W + 1;
   localparam int ENT_W     = OP_W + 2 * WIDTH;
   // WAIT lasts ALU_LAT-1 cycles: the counter runs from ALU_LAT-2 down to 0.
   localparam int WAIT_INIT = (ALU_LAT > 1) ? ALU_LAT - 2 : 0;
   localparam int WCNT_W    = (WAIT_INIT > 1) ? $clog2(WAIT_INIT + 1) : 1;

   localparam logic [OP_W-1:0] OP_ADD = 4'b1000;
   localparam logic [OP_W-1:0] OP_SUB = 4'b1001;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_CAPT  = 3'd3,
      S_CLR   = 3'd4
   } state_t;

   // Opcodes the ALU does not implement; they must never reach it.
   function automatic logic is_illegal(input logic [OP_W-1:0] op);
      logic ill;
      case (op)
         4'b0111, 4'b1100, 4'b1101, 4'b1110: ill = 1'b1;
         default:                            ill = 1'b0;
      endcase
      return ill;
   endfunction

   // Only the adder produces a meaningful overflow flag.
   function automatic logic is_arith(input logic [OP_W-1:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

   logic [ENT_W-1:0] fifo_mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             capture;
   logic [OP_W-1:0]  head_op;
   logic [WIDTH-1:0] head_a;
   logic [WIDTH-1:0] head_b;
   logic [WCNT_W-1:0] wait_cnt;
   logic             cur_illegal;
   logic             cur_arith;
   logic             cur_clear;
   state_t           state;
   state_t           state_nx;

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign cmd_ready = !full && !rst;
   assign push      = cmd_valid && cmd_ready;
   assign busy      = (state != S_IDLE) || !empty;
   assign {head_op, head_a, head_b} = fifo_mem[rd_ptr];

   // Next-state decode; pop and capture are the only side effects of the FSM.
   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      capture  = 1'b0;
      case (state)
         S_IDLE: begin
            if (!empty) begin
               pop      = 1'b1;
               state_nx = S_ISSUE;
            end else begin
               state_nx = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (ALU_LAT > 1) begin
               state_nx = S_WAIT;
            end else begin
               state_nx = S_CAPT;
            end
         end
         S_WAIT: begin
            if (wait_cnt == '0) begin
               state_nx = S_CAPT;
            end else begin
               state_nx = S_WAIT;
            end
         end
         S_CAPT: begin
            // Capture only when the result slot is free or being emptied now.
            if (!res_valid || res_ready) begin
               capture  = 1'b1;
               state_nx = S_CLR;
            end else begin
               state_nx = S_CAPT;
            end
         end
         S_CLR: begin
            if (!empty) begin
               pop      = 1'b1;
               state_nx = S_ISSUE;
            end else begin
               state_nx = S_IDLE;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Command FIFO storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_mem[i] <= '0;
         end
      end else if (push) begin
         fifo_mem[wr_ptr] <= {cmd_opcode, cmd_a, cmd_b};
      end
   end

   // FIFO pointers (wrap naturally, DEPTH is a power of two) and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // WAIT-state latency counter, armed while in ISSUE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (state == S_ISSUE) begin
         wait_cnt <= WCNT_W'(WAIT_INIT);
      end else if ((state == S_WAIT) && (wait_cnt != '0)) begin
         wait_cnt <= wait_cnt - 1'b1;
      end
   end

   // ALU drive and current-op attributes: loaded on pop, cleared after capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_opcode  <= CLEAR_OP;
         alu_a       <= '0;
         alu_b       <= '0;
         cur_illegal <= 1'b0;
         cur_arith   <= 1'b0;
         cur_clear   <= 1'b0;
      end else if (pop) begin
         // An unsupported opcode is replaced by CLEAR so the ALU never sees it.
         alu_opcode  <= is_illegal(head_op) ? CLEAR_OP : head_op;
         alu_a       <= head_a;
         alu_b       <= head_b;
         cur_illegal <= is_illegal(head_op);
         cur_arith   <= is_arith(head_op);
         cur_clear   <= (head_op == CLEAR_OP);
      end else if (capture) begin
         alu_opcode  <= CLEAR_OP;
         alu_a       <= '0;
         alu_b       <= '0;
      end
   end

   // Result holding register with valid/ready handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_valid    <= 1'b0;
         res_data     <= '0;
         res_overflow <= 1'b0;
         res_illegal  <= 1'b0;
      end else if (capture) begin
         res_valid    <= 1'b1;
         res_data     <= (cur_illegal || cur_clear) ? '0 : alu_result;
         res_overflow <= cur_arith && alu_overflow;
         res_illegal  <= cur_illegal;
      end else if (res_valid && res_ready) begin
         res_valid    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
//   Self-checking bench for alu_op_sequencer. Two instances: one with ALU_LAT=1
//   for the main directed and randomized traffic, one with ALU_LAT=3 for the
//   WAIT-state latency and mid-op reset behaviour. Each instance is fed by a
//   small behavioural ALU stub with the matching register latency. Results of
//   the main instance are compared against a scoreboard of expected results
//   computed when each command is accepted.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

   localparam int DEPTH = 4;
   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_XOR = 4'b0010;
   localparam logic [3:0] OP_ADD = 4'b1000;
   localparam logic [3:0] OP_SUB = 4'b1001;
   localparam logic [3:0] OP_CLR = 4'b1111;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main instance (ALU_LAT = 1)
   logic        rst, cmd_valid, cmd_ready;
   logic [3:0]  cmd_opcode, alu_opcode;
   logic [15:0] cmd_a, cmd_b, alu_a, alu_b, alu_result, res_data;
   logic        alu_overflow, res_valid, res_ready, res_overflow, res_illegal, busy;

   // second instance (ALU_LAT = 3)
   logic        rst3, cmd_valid3, cmd_ready3;
   logic [3:0]  cmd_opcode3, alu_opcode3;
   logic [15:0] cmd_a3, cmd_b3, alu_a3, alu_b3, alu_result3, res_data3;
   logic        alu_overflow3, res_valid3, res_ready3, res_overflow3, res_illegal3, busy3;

   alu_op_sequencer #(.WIDTH(16), .OP_W(4), .DEPTH(DEPTH), .ALU_LAT(1), .CLEAR_OP(4'b1111)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_overflow(alu_overflow),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_overflow(res_overflow), .res_illegal(res_illegal), .busy(busy));

   alu_op_sequencer #(.WIDTH(16), .OP_W(4), .DEPTH(DEPTH), .ALU_LAT(3), .CLEAR_OP(4'b1111)) dut3 (
      .clk(clk), .rst(rst3), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
      .cmd_opcode(cmd_opcode3), .cmd_a(cmd_a3), .cmd_b(cmd_b3),
      .alu_opcode(alu_opcode3), .alu_a(alu_a3), .alu_b(alu_b3),
      .alu_result(alu_result3), .alu_overflow(alu_overflow3),
      .res_valid(res_valid3), .res_ready(res_ready3), .res_data(res_data3),
      .res_overflow(res_overflow3), .res_illegal(res_illegal3), .busy(busy3));

   // Behavioural ALU: {overflow, result}. Non-adder ops report overflow=1 so
   // that the sequencer's masking of the flag is observable.
   function automatic logic [16:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [15:0] s;
      case (op)
         OP_AND: return {1'b1, a & b};
         OP_OR:  return {1'b1, a | b};
         OP_XOR: return {1'b1, a ^ b};
         OP_ADD: begin s = a + b; return {(a[15] == b[15]) && (s[15] != a[15]), s}; end
         OP_SUB: begin s = a - b; return {(a[15] != b[15]) && (s[15] != a[15]), s}; end
         OP_CLR: return {1'b1, 16'h0000};
         default: return {1'b1, (a ^ 16'h5A5A) + b};
      endcase
   endfunction

   function automatic logic is_ill(input logic [3:0] op);
      return (op == 4'b0111) || (op == 4'b1100) || (op == 4'b1101) || (op == 4'b1110);
   endfunction

   // Expected {illegal, overflow, data} for one command.
   function automatic logic [17:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [16:0] r;
      if (is_ill(op)) return {1'b1, 1'b0, 16'h0000};
      r = alu_f(op, a, b);
      return {1'b0, (op == OP_ADD || op == OP_SUB) ? r[16] : 1'b0, r[15:0]};
   endfunction

   // ALU stubs: one input register stage, and three for the ALU_LAT=3 instance.
   logic [35:0] alu_q = '0;
   logic [35:0] p3 [3] = '{default: '0};
   always @(posedge clk) begin
      alu_q <= {alu_opcode, alu_a, alu_b};
      p3[0] <= {alu_opcode3, alu_a3, alu_b3};
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign {alu_overflow, alu_result}   = alu_f(alu_q[35:32], alu_q[31:16], alu_q[15:0]);
   assign {alu_overflow3, alu_result3} = alu_f(p3[2][35:32], p3[2][31:16], p3[2][15:0]);

   int total = 0;
   int bad   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: expected results queued on accept, compared on consume.
   logic [17:0] sb [$];
   int n_res = 0;
   always @(negedge clk) begin
      if (!rst) begin
         if (res_valid && res_ready) begin
            check_eq("sb_nonempty", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
               check_eq("result", {res_illegal, res_overflow, res_data}, sb.pop_front());
            end
            n_res++;
         end
         if (cmd_valid && cmd_ready) begin
            sb.push_back(model(cmd_opcode, cmd_a, cmd_b));
         end
      end
      check_eq("alu_op_legal", is_ill(alu_opcode), 1'b0);
      check_eq("alu3_op_legal", is_ill(alu_opcode3), 1'b0);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      int n = 0;
      cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
      while (!cmd_ready && n < 50) begin step(); n++; end
      check_eq("send_ready", cmd_ready, 1'b1);
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_result(input string tag, input logic [15:0] d, input logic o, input logic i);
      int n = 0;
      while (!res_valid && n < 50) begin step(); n++; end
      check_eq({tag, "_valid"}, res_valid, 1'b1);
      check_eq({tag, "_data"}, res_data, d);
      check_eq({tag, "_ovf"}, res_overflow, o);
      check_eq({tag, "_ill"}, res_illegal, i);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
   endtask

   task automatic drain(input string tag, input int exp_n);
      int n = 0;
      int n0 = n_res;
      res_ready = 1'b1;
      cmd_valid = 1'b0;
      while ((busy || res_valid) && n < 400) begin step(); n++; end
      check_eq({tag, "_idle"}, busy || res_valid, 1'b0);
      if (exp_n >= 0) check_eq({tag, "_count"}, n_res - n0, exp_n);
      check_eq({tag, "_sb_empty"}, sb.size(), 0);
      res_ready = 1'b0;
   endtask

   logic [3:0]  legal_ops [5] = '{OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB};
   logic [15:0] corners   [4] = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};
   logic [3:0]  first_op;
   int          acc;

   initial begin
      rst = 1'b0; rst3 = 1'b0;
      cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
      cmd_valid3 = 1'b0; cmd_opcode3 = '0; cmd_a3 = '0; cmd_b3 = '0; res_ready3 = 1'b0;
      #1 rst = 1'b1; rst3 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_alu_op", alu_opcode, OP_CLR);
      check_eq("rst_alu_a", alu_a, 16'h0000);
      check_eq("rst_alu_b", alu_b, 16'h0000);
      check_eq("rst_res_valid", res_valid, 1'b0);
      check_eq("rst_res_data", res_data, 16'h0000);
      check_eq("rst_res_ovf", res_overflow, 1'b0);
      check_eq("rst_res_ill", res_illegal, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_cmd_ready", cmd_ready, 1'b0);
      rst = 1'b0; rst3 = 1'b0;
      #1 check_eq("ready_after_rst", cmd_ready, 1'b1);
      step();

      // ADD latency: accepted at edge E, ISSUE after E+1, res_valid after E+3.
      cmd_opcode = OP_ADD; cmd_a = 16'h001E; cmd_b = 16'h0007; cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      step();
      check_eq("lat_issue_op", alu_opcode, OP_ADD);
      check_eq("lat_issue_a", alu_a, 16'h001E);
      check_eq("lat_v1", res_valid, 1'b0);
      step();
      check_eq("lat_v2", res_valid, 1'b0);
      step();
      check_eq("lat_v3", res_valid, 1'b1);
      check_eq("lat_data", res_data, 16'h0025);
      check_eq("lat_ovf", res_overflow, 1'b0);
      check_eq("lat_clr_op", alu_opcode, OP_CLR);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;

      send(OP_ADD, 16'hBC40, 16'h9C40);  wait_result("add_ovf", 16'h5880, 1'b1, 1'b0);
      send(OP_SUB, 16'h001E, 16'h0007);  wait_result("sub", 16'h0017, 1'b0, 1'b0);
      send(4'b1100, 16'h1234, 16'h5678); wait_result("illegal", 16'h0000, 1'b0, 1'b1);
      send(OP_CLR, 16'hFFFF, 16'h0001);  wait_result("clear_cmd", 16'h0000, 1'b0, 1'b0);
      send(OP_XOR, 16'hFFFF, 16'h8001);  wait_result("xor_novf", 16'h7FFE, 1'b0, 1'b0);

      // AND then OR back-to-back, consumer always ready.
      res_ready = 1'b1;
      cmd_opcode = OP_AND; cmd_a = 16'h250A; cmd_b = 16'h6C36; cmd_valid = 1'b1;
      step();
      cmd_opcode = OP_OR;
      step();
      cmd_valid = 1'b0;
      begin
         logic [3:0]  exp_op [6] = '{OP_AND, OP_AND, OP_CLR, OP_OR, OP_OR, OP_CLR};
         logic        exp_rv [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
         for (int k = 0; k < 6; k++) begin
            if (k > 0) step();
            check_eq($sformatf("b2b_op%0d", k + 1), alu_opcode, exp_op[k]);
            check_eq($sformatf("b2b_rv%0d", k + 1), res_valid, exp_rv[k]);
            if (k == 2) check_eq("b2b_and", res_data, 16'h2402);
            if (k == 5) check_eq("b2b_or", res_data, 16'h6D3E);
         end
      end
      step();
      res_ready = 1'b0;

      // Flood with a result already held: DEPTH queued plus one stalled in CAPT.
      send(OP_XOR, 16'hAAAA, 16'h0F0F);
      begin
         int n = 0;
         while (!res_valid && n < 50) begin step(); n++; end
      end
      check_eq("flood_pending", res_valid, 1'b1);
      acc = 0;
      cmd_valid = 1'b1;
      for (int k = 0; k < 3 * DEPTH + 12; k++) begin
         cmd_opcode = legal_ops[$urandom_range(0, 4)];
         cmd_a = 16'($urandom);
         cmd_b = 16'($urandom);
         if (k == 0) first_op = cmd_opcode;
         if (cmd_ready) acc++;
         step();
      end
      cmd_valid = 1'b0;
      check_eq("flood_accepted", acc, DEPTH + 1);
      check_eq("flood_ready_low", cmd_ready, 1'b0);
      check_eq("flood_busy", busy, 1'b1);
      check_eq("flood_stall_op", alu_opcode, first_op);
      drain("flood_drain", DEPTH + 2);

      // Randomized traffic with random back-pressure and all opcodes.
      for (int k = 0; k < 600; k++) begin
         cmd_valid  = ($urandom_range(0, 2) != 0);
         cmd_opcode = 4'($urandom_range(0, 15));
         cmd_a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
         cmd_b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
         res_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      drain("rand_drain", -1);

      // ALU_LAT=3: accepted at E, res_valid first high after E+5.
      cmd_opcode3 = OP_ADD; cmd_a3 = 16'h7FFF; cmd_b3 = 16'h0001; cmd_valid3 = 1'b1;
      step();
      cmd_valid3 = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         step();
         check_eq($sformatf("lat3_rv%0d", k), res_valid3, (k == 5));
      end
      check_eq("lat3_data", res_data3, 16'h8000);
      check_eq("lat3_ovf", res_overflow3, 1'b1);
      res_ready3 = 1'b1;
      step();
      res_ready3 = 1'b0;
      step();

      // Reset during WAIT with two commands queued.
      cmd_valid3 = 1'b1;
      cmd_opcode3 = OP_SUB; cmd_a3 = 16'h0100; cmd_b3 = 16'h0001;
      step();
      cmd_opcode3 = OP_AND;
      step();
      cmd_opcode3 = OP_OR;
      step();
      cmd_valid3 = 1'b0;
      check_eq("w_op_held", alu_opcode3, OP_SUB);
      check_eq("w_busy", busy3, 1'b1);
      #2 rst3 = 1'b1;
      #1;
      check_eq("w_rst_op", alu_opcode3, OP_CLR);
      check_eq("w_rst_a", alu_a3, 16'h0000);
      check_eq("w_rst_b", alu_b3, 16'h0000);
      check_eq("w_rst_rv", res_valid3, 1'b0);
      check_eq("w_rst_data", res_data3, 16'h0000);
      check_eq("w_rst_busy", busy3, 1'b0);
      step();
      rst3 = 1'b0;
      #1 check_eq("w_ready_after", cmd_ready3, 1'b1);
      for (int k = 0; k < 10; k++) begin
         step();
         check_eq("w_no_result", res_valid3, 1'b0);
         check_eq("w_idle", busy3, 1'b0);
      end
      check_eq("w_ready_final", cmd_ready3, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end

endmodule
